// File: rtl/quad_encoder_gen_if.sv
// Command channel of the quadrature generator: one motion command per
// valid/ready handshake, plus an abort line for the running command.
interface quad_encoder_gen_if #(
  parameter int STEPBITS   = 16,
  parameter int PERIODBITS = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [STEPBITS-1:0]   cmd_steps;
  logic [PERIODBITS-1:0] cmd_period;
  logic                  abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator: emits a commanded number of Gray-coded edges at a
// fixed clocks-per-state rate and tracks the position a decoder would report.
module quad_encoder_gen #(
  parameter int COUNTBITS  = 24,
  parameter int STEPBITS   = 16,
  parameter int PERIODBITS = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  quad_encoder_gen_if.slave    cmd,
  output logic                 A,
  output logic                 B,
  output logic                 busy,
  output logic                 done,
  output logic [COUNTBITS-1:0] pos_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic                  dir_reg, dir_next;
  logic [STEPBITS-1:0]   remaining_reg, remaining_next;
  logic [PERIODBITS-1:0] period_reg, period_next;
  logic [PERIODBITS-1:0] timer_reg, timer_next;
  logic [1:0]            phase_reg, phase_next;
  logic [COUNTBITS-1:0]  pos_reg, pos_next;
  logic                  done_reg, done_next;
  logic [PERIODBITS-1:0] period_eff;

  // Periods below 2 would let a 2-flop synchronised decoder miss a state.
  assign period_eff = (cmd.cmd_period < PERIODBITS'(2)) ? PERIODBITS'(2) : cmd.cmd_period;

  // {A,B} walks 00->10->11->01 forward; reverse is the inverse walk.
  function automatic logic [1:0] step_phase(input logic [1:0] ph, input logic fwd);
    logic [1:0] r;
    case (ph)
      2'b00:   r = fwd ? 2'b10 : 2'b01;
      2'b10:   r = fwd ? 2'b11 : 2'b00;
      2'b11:   r = fwd ? 2'b01 : 2'b10;
      default: r = fwd ? 2'b00 : 2'b11;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next     = state_reg;
    dir_next       = dir_reg;
    remaining_next = remaining_reg;
    period_next    = period_reg;
    timer_next     = timer_reg;
    phase_next     = phase_reg;
    pos_next       = pos_reg;
    done_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          dir_next       = cmd.cmd_dir;
          remaining_next = cmd.cmd_steps;
          period_next    = period_eff;
          timer_next     = period_eff - PERIODBITS'(1);
          if (cmd.cmd_steps == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      default: begin
        // Abort takes priority over an edge that is due this same cycle.
        if (cmd.abort) begin
          state_next     = ST_IDLE;
          done_next      = 1'b1;
          timer_next     = '0;
          remaining_next = '0;
        end else if (timer_reg == '0) begin
          phase_next     = step_phase(phase_reg, dir_reg);
          pos_next       = dir_reg ? pos_reg + COUNTBITS'(1) : pos_reg - COUNTBITS'(1);
          remaining_next = remaining_reg - STEPBITS'(1);
          timer_next     = period_reg - PERIODBITS'(1);
          if (remaining_reg == STEPBITS'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else begin
          timer_next = timer_reg - PERIODBITS'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dir_reg       <= 1'b0;
      remaining_reg <= '0;
      period_reg    <= '0;
      timer_reg     <= '0;
      phase_reg     <= 2'b00;
      pos_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      remaining_reg <= remaining_next;
      period_reg    <= period_next;
      timer_reg     <= timer_next;
      phase_reg     <= phase_next;
      pos_reg       <= pos_next;
      done_reg      <= done_next;
    end
  end

  assign cmd.cmd_ready = (state_reg == ST_IDLE);
  assign busy          = (state_reg == ST_RUN);
  assign A             = phase_reg[1];
  assign B             = phase_reg[0];
  assign pos_out       = pos_reg;
  assign done          = done_reg;

endmodule
